// File: rtl/gate_response_checker.sv
// gate_response_checker: judges the output of a two-input gate in hardware.
// Samples (a, b, y) triples while a run is active and compares y against the
// TRUTH table indexed by {a,b}. It tracks combo coverage, counts mismatches
// (saturating), captures the first failing combo and reports pass/timeout
// once the run ends.
// Build option: define HALT_ON_ERR_EN to end a run on its first mismatch.
module gate_response_checker #(
  parameter logic [3:0] TRUTH       = 4'b0111,
  parameter int         CNT_W       = 8,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [1:0]       first_err_idx
);

  localparam int                 TIMER_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic [1:0]       idx;
  logic             mismatch;
  logic [3:0]       cov_next;
  logic [CNT_W-1:0] err_next;
  logic             cov_full;
  logic             timer_last;
  logic             halt;

  assign idx = {a, b};

  // Next-state view of the current sample: coverage, error count and exit causes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mismatch   = 1'b0;
    cov_next   = cov;
    err_next   = err_cnt;
    halt       = 1'b0;
    if (valid) begin
      mismatch = (y != TRUTH[idx]);
      cov_next = cov | (4'b0001 << idx);
    end
    if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_next = err_cnt + CNT_W'(1);
    end
    cov_full   = (cov_next == 4'hF);
    timer_last = (timer == TIMER_LAST);
`ifdef HALT_ON_ERR_EN
    halt = mismatch;
`else
    halt = 1'b0;
`endif
  end

  // Run-control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      cov             <= 4'b0000;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= CHECK;
            timer           <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            cov             <= 4'b0000;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= 2'b00;
          end
        end
        CHECK: begin
          cov     <= cov_next;
          err_cnt <= err_next;
          timer   <= timer + TIMER_W'(1);
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx;
          end
          // Full coverage outranks halt and timeout; the current sample is already folded in.
          if (cov_full) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next == '0);
            timeout <= 1'b0;
          end else if (halt) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b0;
          end else if (timer_last) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker. Two instances share the stimulus:
// u_main (TIMEOUT_CYC=16, CNT_W=8) and u_sat (CNT_W=2, TIMEOUT_CYC=64).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that consumed the sample.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n, start, valid, a, b, y;

  logic       m_busy, m_done, m_pass, m_timeout, m_fev;
  logic [3:0] m_cov;
  logic [7:0] m_err;
  logic [1:0] m_fei;

  logic       s_busy, s_done, s_pass, s_timeout, s_fev;
  logic [3:0] s_cov;
  logic [1:0] s_err;
  logic [1:0] s_fei;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.TRUTH(4'b0111), .CNT_W(8), .TIMEOUT_CYC(16)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .a(a), .b(b), .y(y),
    .busy(m_busy), .done(m_done), .pass(m_pass), .timeout(m_timeout), .cov(m_cov),
    .err_cnt(m_err), .first_err_valid(m_fev), .first_err_idx(m_fei)
  );

  gate_response_checker #(.TRUTH(4'b0111), .CNT_W(2), .TIMEOUT_CYC(64)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .a(a), .b(b), .y(y),
    .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .cov(s_cov),
    .err_cnt(s_err), .first_err_valid(s_fev), .first_err_idx(s_fei)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, let the rising edge consume it, return on the falling edge.
  task automatic step(input logic s, input logic v, input logic aa, input logic bb, input logic yy);
    start = s; valid = v; a = aa; b = bb; y = yy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Four correct NAND samples, in {a,b} order.
  task automatic nand_sweep();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_cov", m_cov, 0);
    check("rst_err", m_err, 0);
    check("rst_fev", m_fev, 0);

    // Reset mid-run: two samples, then reset, then samples without start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mid_busy", m_busy, 1);
    check("mid_cov", m_cov, 4'b0011);
    do_reset();
    check("midrst_busy", m_busy, 0);
    check("midrst_cov", m_cov, 0);
    check("midrst_err", m_err, 0);
    check("midrst_done", m_done, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_cov", m_cov, 0);
    check("idle_err", m_err, 0);
    check("idle_busy", m_busy, 0);

    // Correct NAND run; a start pulse mid-run must not restart it.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chk_busy", m_busy, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("start_ignored_cov", m_cov, 4'b0111);
    check("not_done_yet", m_done, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("nand_done", m_done, 1);
    check("nand_pass", m_pass, 1);
    check("nand_cov", m_cov, 4'hF);
    check("nand_err", m_err, 0);
    check("nand_timeout", m_timeout, 0);
    check("nand_busy", m_busy, 0);
    // Samples in DONE are ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("done_hold_err", m_err, 0);
    check("done_hold_done", m_done, 1);

    // Restart from DONE, then a second passing sweep.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_done", m_done, 0);
    check("restart_busy", m_busy, 1);
    check("restart_cov", m_cov, 0);
    check("restart_pass", m_pass, 0);
    nand_sweep();
    check("rerun_done", m_done, 1);
    check("rerun_pass", m_pass, 1);
    check("rerun_cov", m_cov, 4'hF);

    // Faulty AND gate under test.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("and1_fev", m_fev, 1);
    check("and1_fei", m_fei, 2'b00);
    check("and1_err", m_err, 1);
`ifdef HALT_ON_ERR_EN
    check("and1_halt_done", m_done, 1);
    check("and1_halt_cov", m_cov, 4'b0001);
`else
    check("and1_done", m_done, 0);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("and_done", m_done, 1);
    check("and_pass", m_pass, 0);
    check("and_timeout", m_timeout, 0);
    check("and_fei", m_fei, 2'b00);
`ifdef HALT_ON_ERR_EN
    check("and_err", m_err, 1);
    check("and_cov", m_cov, 4'b0001);
`else
    check("and_err", m_err, 4);
    check("and_cov", m_cov, 4'hF);
`endif

    // Timeout on u_main: only combo 00, correct value, repeated.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("to_not_yet", m_done, 0);
    check("to_busy", m_busy, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("to_done", m_done, 1);
    check("to_timeout", m_timeout, 1);
    check("to_pass", m_pass, 0);
    check("to_cov", m_cov, 4'b0001);
    check("to_err", m_err, 0);
    check("to_sat_busy", s_busy, 1);

    // Saturation on u_sat: five mismatches on combo 11, then complete coverage.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef HALT_ON_ERR_EN
    check("sat_err", s_err, 1);
    check("sat_done", s_done, 1);
    check("sat_cov", s_cov, 4'b1000);
`else
    check("sat_err", s_err, 3);
    check("sat_busy", s_busy, 1);
    check("sat_main_err", m_err, 5);
`endif
    check("sat_fei", s_fei, 2'b11);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_end_done", s_done, 1);
    check("sat_end_pass", s_pass, 0);
    check("sat_end_timeout", s_timeout, 0);
`ifdef HALT_ON_ERR_EN
    check("sat_end_err", s_err, 1);
`else
    check("sat_end_err", s_err, 3);
    check("sat_end_cov", s_cov, 4'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
